// File: rtl/acc_cpu_mc.sv
// -----------------------------------------------------------------------------
// acc_cpu_mc - multicycle accumulator CPU (Harvard, synchronous-read memories)
//
// Each instruction runs FETCH -> DECODE -> EXEC, plus a MEM cycle for the ops
// that read data memory. HLT parks the core in HALT until reset.
//
// Ports
//   clk           clock, all state changes on the rising edge
//   reset         asynchronous, active-low reset
//   addr_program  program address (the PC)
//   data          instruction word, valid the cycle after addr_program
//   wr            data-memory write strobe (EXEC of STO only)
//   addr_data     data address (operand field of the IR)
//   in_data       read data, valid the cycle after addr_data
//   out_data      write data (the accumulator)
//   acc           accumulator
//   wr_pc         high in the cycle the PC is written
//   halted        high while in HALT
// -----------------------------------------------------------------------------
module acc_cpu_mc #(
    parameter int ADDR_BITS  = 11,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_BITS-1:0]  addr_program,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  wr,
    output logic [ADDR_BITS-1:0]  addr_data,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [DATA_WIDTH-1:0] acc,
    output logic                  wr_pc,
    output logic                  halted
);

    localparam int OPCODE_BITS = DATA_WIDTH - ADDR_BITS;

    // The opcode map below needs 5 opcode bits.
    generate
        if (OPCODE_BITS < 5) begin : g_bad_params
            $error("acc_cpu_mc: DATA_WIDTH - ADDR_BITS must be at least 5");
        end
    endgenerate

    localparam logic [OPCODE_BITS-1:0] OP_HLT  = OPCODE_BITS'(0);
    localparam logic [OPCODE_BITS-1:0] OP_STO  = OPCODE_BITS'(1);
    localparam logic [OPCODE_BITS-1:0] OP_LD   = OPCODE_BITS'(2);
    localparam logic [OPCODE_BITS-1:0] OP_LDI  = OPCODE_BITS'(3);
    localparam logic [OPCODE_BITS-1:0] OP_ADD  = OPCODE_BITS'(4);
    localparam logic [OPCODE_BITS-1:0] OP_ADDI = OPCODE_BITS'(5);
    localparam logic [OPCODE_BITS-1:0] OP_SUB  = OPCODE_BITS'(6);
    localparam logic [OPCODE_BITS-1:0] OP_SUBI = OPCODE_BITS'(7);
    localparam logic [OPCODE_BITS-1:0] OP_AND  = OPCODE_BITS'(8);
    localparam logic [OPCODE_BITS-1:0] OP_ANDI = OPCODE_BITS'(9);
    localparam logic [OPCODE_BITS-1:0] OP_OR   = OPCODE_BITS'(10);
    localparam logic [OPCODE_BITS-1:0] OP_ORI  = OPCODE_BITS'(11);
    localparam logic [OPCODE_BITS-1:0] OP_XOR  = OPCODE_BITS'(12);
    localparam logic [OPCODE_BITS-1:0] OP_XORI = OPCODE_BITS'(13);
    localparam logic [OPCODE_BITS-1:0] OP_JMP  = OPCODE_BITS'(14);
    localparam logic [OPCODE_BITS-1:0] OP_BEQ  = OPCODE_BITS'(15);
    localparam logic [OPCODE_BITS-1:0] OP_BNE  = OPCODE_BITS'(16);
    localparam logic [OPCODE_BITS-1:0] OP_BLT  = OPCODE_BITS'(17);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    state_t                  state_reg;
    logic [ADDR_BITS-1:0]    pc_reg;
    logic [DATA_WIDTH-1:0]   acc_reg;
    logic [DATA_WIDTH-1:0]   ir_reg;

    logic [OPCODE_BITS-1:0]  opcode;
    logic [ADDR_BITS-1:0]    operand;
    logic [DATA_WIDTH-1:0]   imm_sext;
    logic [ADDR_BITS-1:0]    pc_plus_one;

    assign opcode      = ir_reg[DATA_WIDTH-1 -: OPCODE_BITS];
    assign operand     = ir_reg[ADDR_BITS-1:0];
    assign pc_plus_one = pc_reg + ADDR_BITS'(1);

    // Sign-extend the operand field for the immediate forms.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_sext
            if (gi < ADDR_BITS) begin : g_low
                assign imm_sext[gi] = operand[gi];
            end else begin : g_high
                assign imm_sext[gi] = operand[ADDR_BITS-1];
            end
        end
    endgenerate

    // Instruction class decode. Branch conditions see the ACC value present
    // during EXEC, i.e. the result of the previous instruction.
    logic is_mem_op;
    logic is_imm_op;
    logic branch_taken;

    always_comb begin
        is_mem_op    = 1'b0;
        is_imm_op    = 1'b0;
        branch_taken = 1'b0;
        case (opcode)
            OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:
                is_mem_op = 1'b1;
            OP_LDI, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI:
                is_imm_op = 1'b1;
            OP_JMP: branch_taken = 1'b1;
            OP_BEQ: branch_taken = (acc_reg == '0);
            OP_BNE: branch_taken = (acc_reg != '0);
            OP_BLT: branch_taken = acc_reg[DATA_WIDTH-1];
            default: ;
        endcase
    end

    // One ALU serves both forms: the B operand is the memory word in MEM and
    // the sign-extended immediate otherwise. LD/LDI simply pass B through.
    logic [DATA_WIDTH-1:0] alu_b;
    logic [DATA_WIDTH-1:0] alu_result;

    assign alu_b = (state_reg == S_MEM) ? in_data : imm_sext;

    always_comb begin
        alu_result = alu_b;
        case (opcode)
            OP_ADD, OP_ADDI: alu_result = acc_reg + alu_b;
            OP_SUB, OP_SUBI: alu_result = acc_reg - alu_b;
            OP_AND, OP_ANDI: alu_result = acc_reg & alu_b;
            OP_OR,  OP_ORI:  alu_result = acc_reg | alu_b;
            OP_XOR, OP_XORI: alu_result = acc_reg ^ alu_b;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_FETCH;
            pc_reg    <= '0;
            acc_reg   <= '0;
            ir_reg    <= '0;
        end else begin
            case (state_reg)
                S_FETCH: begin
                    state_reg <= S_DECODE;
                end
                S_DECODE: begin
                    ir_reg    <= data;
                    state_reg <= S_EXEC;
                end
                S_EXEC: begin
                    if (opcode == OP_HLT) begin
                        state_reg <= S_HALT;
                    end else if (is_mem_op) begin
                        // PC advances only after the memory word is consumed.
                        state_reg <= S_MEM;
                    end else begin
                        if (is_imm_op) begin
                            acc_reg <= alu_result;
                        end
                        pc_reg    <= branch_taken ? operand : pc_plus_one;
                        state_reg <= S_FETCH;
                    end
                end
                S_MEM: begin
                    acc_reg   <= alu_result;
                    pc_reg    <= pc_plus_one;
                    state_reg <= S_FETCH;
                end
                S_HALT: begin
                    state_reg <= S_HALT;
                end
                default: begin
                    state_reg <= S_FETCH;
                end
            endcase
        end
    end

    assign addr_program = pc_reg;
    assign addr_data    = operand;
    assign out_data     = acc_reg;
    assign acc          = acc_reg;
    assign halted       = (state_reg == S_HALT);
    assign wr           = (state_reg == S_EXEC) && (opcode == OP_STO);
    assign wr_pc        = ((state_reg == S_EXEC) && !is_mem_op && (opcode != OP_HLT))
                          || (state_reg == S_MEM);

endmodule

// File: tb/tb_acc_cpu_mc.sv
`timescale 1ns/1ps
module tb_acc_cpu_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main instance (ADDR_BITS=11, DATA_WIDTH=16) -----------
    logic        reset;
    logic [10:0] addr_program;
    logic [10:0] addr_data;
    logic [15:0] prog_data;
    logic [15:0] rd_data;
    logic [15:0] out_data;
    logic [15:0] acc;
    logic        wr;
    logic        wr_pc;
    logic        halted;

    acc_cpu_mc #(.ADDR_BITS(11), .DATA_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .addr_program(addr_program), .data(prog_data),
        .wr(wr), .addr_data(addr_data), .in_data(rd_data), .out_data(out_data),
        .acc(acc), .wr_pc(wr_pc), .halted(halted)
    );

    logic [15:0] pmem [2048];
    logic [15:0] dmem [2048];
    logic        ld_en = 1'b0;
    logic [10:0] ld_addr = '0;
    logic [15:0] ld_val = '0;

    always @(posedge clk) begin
        prog_data <= pmem[addr_program];
        rd_data   <= dmem[addr_data];
        if (ld_en)   dmem[ld_addr]   <= ld_val;
        else if (wr) dmem[addr_data] <= out_data;
    end

    // ---------------- small instance (ADDR_BITS=4, DATA_WIDTH=12) -----------
    logic        p2_reset;
    logic [3:0]  p2_addr_program;
    logic [3:0]  p2_addr_data;
    logic [11:0] p2_data;
    logic [11:0] p2_in_data;
    logic [11:0] p2_out_data;
    logic [11:0] p2_acc;
    logic        p2_wr;
    logic        p2_wr_pc;
    logic        p2_halted;
    logic [11:0] p2_pmem [16];

    assign p2_in_data = 12'h000;

    acc_cpu_mc #(.ADDR_BITS(4), .DATA_WIDTH(12)) dut_small (
        .clk(clk), .reset(p2_reset), .addr_program(p2_addr_program), .data(p2_data),
        .wr(p2_wr), .addr_data(p2_addr_data), .in_data(p2_in_data), .out_data(p2_out_data),
        .acc(p2_acc), .wr_pc(p2_wr_pc), .halted(p2_halted)
    );

    always @(posedge clk) p2_data <= p2_pmem[p2_addr_program];

    // ---------------- checking helpers ---------------------------------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic dm_write(input logic [10:0] a, input logic [15:0] v);
        ld_addr = a;
        ld_val  = v;
        ld_en   = 1'b1;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
    endtask

    task automatic clear_pmem();
        for (int i = 0; i < 2048; i++) pmem[i] = 16'h0000;
    endtask

    // Holds reset for a couple of cycles, releases it on a falling edge and
    // leaves the caller at the cycle-0 sample point (first FETCH).
    task automatic pulse_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic run_to_halt(input int budget, output int cyc, output int n_wr_pc,
                               output int n_wr, output logic [10:0] w_addr,
                               output logic [15:0] w_val);
        cyc = -1; n_wr_pc = 0; n_wr = 0; w_addr = '0; w_val = '0;
        for (int k = 0; k < budget; k++) begin
            if (halted === 1'b1) begin
                cyc = k;
                break;
            end
            if (wr_pc === 1'b1) n_wr_pc++;
            if (wr === 1'b1) begin
                n_wr++;
                w_addr = addr_data;
                w_val  = out_data;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- directed program table ---------------------------------
    typedef struct packed {
        logic [15:0][15:0] prog;
        logic [15:0]       exp_acc;
        int                exp_cycles;   // cycle index at which halted first reads 1
        int                exp_wr_pc;
        int                exp_wr;
        logic [10:0]       exp_wr_addr;
        logic [15:0]       exp_wr_val;
        logic [10:0]       exp_pc;
    } vec_t;

    vec_t vecs [4];

    // ---------------- reference model for random programs -------------------
    task automatic run_random(input int idx);
        logic [15:0] m_dm [32];
        logic [15:0] m_acc, ir, imm, pre_acc, w_val;
        logic [10:0] m_pc, next_pc, opd, w_addr;
        logic [4:0]  op;
        logic        is_halt, exp_wr;
        int          cyc, n_wr, n_wr_pc, n_instr;

        reset = 1'b0;
        clear_pmem();
        for (int i = 0; i < 32; i++) begin
            op = 5'($urandom_range(0, 21));
            if (op == 5'd0 && $urandom_range(0, 3) != 0) op = 5'd3;
            if (op >= 5'd18 && $urandom_range(0, 1) != 0) op = 5'd31;
            if (op inside {5'd1, 5'd2, 5'd4, 5'd6, 5'd8, 5'd10, 5'd12,
                           5'd14, 5'd15, 5'd16, 5'd17})
                opd = 11'($urandom_range(0, 31));
            else
                opd = 11'($urandom_range(0, 2047));
            pmem[i] = {op, opd};
        end
        for (int i = 0; i < 32; i++) begin
            m_dm[i] = 16'($urandom);
            dm_write(11'(i), m_dm[i]);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;

        m_acc = '0;
        m_pc  = '0;
        for (n_instr = 0; n_instr < 40; n_instr++) begin
            ir      = pmem[m_pc];
            op      = ir[15:11];
            opd     = ir[10:0];
            imm     = {{5{opd[10]}}, opd};
            pre_acc = m_acc;
            cyc     = 3;
            is_halt = 1'b0;
            exp_wr  = 1'b0;
            next_pc = m_pc + 11'd1;
            case (op)
                5'd0:  begin is_halt = 1'b1; next_pc = m_pc; end
                5'd1:  begin m_dm[opd[4:0]] = m_acc; exp_wr = 1'b1; end
                5'd2:  begin m_acc = m_dm[opd[4:0]]; cyc = 4; end
                5'd3:  m_acc = imm;
                5'd4:  begin m_acc = m_acc + m_dm[opd[4:0]]; cyc = 4; end
                5'd5:  m_acc = m_acc + imm;
                5'd6:  begin m_acc = m_acc - m_dm[opd[4:0]]; cyc = 4; end
                5'd7:  m_acc = m_acc - imm;
                5'd8:  begin m_acc = m_acc & m_dm[opd[4:0]]; cyc = 4; end
                5'd9:  m_acc = m_acc & imm;
                5'd10: begin m_acc = m_acc | m_dm[opd[4:0]]; cyc = 4; end
                5'd11: m_acc = m_acc | imm;
                5'd12: begin m_acc = m_acc ^ m_dm[opd[4:0]]; cyc = 4; end
                5'd13: m_acc = m_acc ^ imm;
                5'd14: next_pc = opd;
                5'd15: if (m_acc == 16'h0000) next_pc = opd;
                5'd16: if (m_acc != 16'h0000) next_pc = opd;
                5'd17: if (m_acc[15]) next_pc = opd;
                default: ;
            endcase

            n_wr = 0; n_wr_pc = 0; w_addr = '0; w_val = '0;
            for (int j = 0; j < cyc; j++) begin
                if (j == 2) chk("rnd_addr_data", 32'(addr_data), 32'(opd));
                if (wr === 1'b1) begin
                    n_wr++;
                    w_addr = addr_data;
                    w_val  = out_data;
                end
                if (wr_pc === 1'b1) n_wr_pc++;
                @(posedge clk);
                #1;
            end

            if (is_halt) begin
                chk("rnd_halted", 32'(halted), 32'd1);
                chk("rnd_halt_pc", 32'(addr_program), 32'(m_pc));
                chk("rnd_halt_acc", 32'(acc), 32'(m_acc));
                chk("rnd_halt_wr_pc", 32'(n_wr_pc), 32'd0);
                chk("rnd_halt_wr", 32'(n_wr), 32'd0);
                break;
            end
            chk("rnd_pc", 32'(addr_program), 32'(next_pc));
            chk("rnd_acc", 32'(acc), 32'(m_acc));
            chk("rnd_not_halted", 32'(halted), 32'd0);
            chk("rnd_wr_pc_count", 32'(n_wr_pc), 32'd1);
            chk("rnd_wr_count", 32'(n_wr), exp_wr ? 32'd1 : 32'd0);
            if (exp_wr) begin
                chk("rnd_wr_addr", 32'(w_addr), 32'(opd));
                chk("rnd_wr_data", 32'(w_val), 32'(pre_acc));
            end
            m_pc = next_pc;
        end
        $display("rand %0d: instrs=%0d pc=%h acc=%h", idx, n_instr, m_pc, m_acc);
    endtask

    // ---------------- main sequence ------------------------------------------
    int          cyc, nwp, nw;
    logic [10:0] wa;
    logic [15:0] wv;
    int          p2_wr_cnt;

    initial begin
        reset    = 1'b1;
        p2_reset = 1'b1;
        for (int i = 0; i < 16; i++) p2_pmem[i] = 12'h000;
        clear_pmem();
        #2;
        reset    = 1'b0;
        p2_reset = 1'b0;
        #1;

        // Reset state of both instances
        chk("rst_addr_program", 32'(addr_program), 32'd0);
        chk("rst_addr_data", 32'(addr_data), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_acc", 32'(acc), 32'd0);
        chk("rst_wr", 32'(wr), 32'd0);
        chk("rst_wr_pc", 32'(wr_pc), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_p2_addr_program", 32'(p2_addr_program), 32'd0);
        chk("rst_p2_acc", 32'(p2_acc), 32'd0);

        // Directed program table
        for (int v = 0; v < 4; v++) vecs[v] = '0;
        // LDI 5; ADDI -3; HLT
        vecs[0].prog[0] = 16'h1805; vecs[0].prog[1] = 16'h2FFD; vecs[0].prog[2] = 16'h0000;
        vecs[0].exp_acc = 16'h0002; vecs[0].exp_cycles = 9; vecs[0].exp_wr_pc = 2;
        vecs[0].exp_wr = 0; vecs[0].exp_pc = 11'd2;
        // LDI 0x123; STO 10; LDI 0; LD 10; HLT
        vecs[1].prog[0] = 16'h1923; vecs[1].prog[1] = 16'h080A; vecs[1].prog[2] = 16'h1800;
        vecs[1].prog[3] = 16'h100A; vecs[1].prog[4] = 16'h0000;
        vecs[1].exp_acc = 16'h0123; vecs[1].exp_cycles = 16; vecs[1].exp_wr_pc = 4;
        vecs[1].exp_wr = 1; vecs[1].exp_wr_addr = 11'd10; vecs[1].exp_wr_val = 16'h0123;
        vecs[1].exp_pc = 11'd4;
        // LDI 0; BEQ 6; (2: HLT; 3..5 trap) 6: BNE 0; 7: JMP 2
        vecs[2].prog[0] = 16'h1800; vecs[2].prog[1] = 16'h7806; vecs[2].prog[2] = 16'h0000;
        vecs[2].prog[3] = 16'h1FFF; vecs[2].prog[4] = 16'h1FFF; vecs[2].prog[5] = 16'h1FFF;
        vecs[2].prog[6] = 16'h8000; vecs[2].prog[7] = 16'h7002;
        vecs[2].exp_acc = 16'h0000; vecs[2].exp_cycles = 15; vecs[2].exp_wr_pc = 4;
        vecs[2].exp_wr = 0; vecs[2].exp_pc = 11'd2;
        // LDI 0; SUBI 1; BLT 9; (3..8 trap) 9: ANDI 0x0F0; XORI 0x7FF; HLT
        vecs[3].prog[0] = 16'h1800; vecs[3].prog[1] = 16'h3801; vecs[3].prog[2] = 16'h8809;
        for (int i = 3; i < 9; i++) vecs[3].prog[i] = 16'h1801;
        vecs[3].prog[9] = 16'h48F0; vecs[3].prog[10] = 16'h6FFF; vecs[3].prog[11] = 16'h0000;
        vecs[3].exp_acc = 16'hFF0F; vecs[3].exp_cycles = 18; vecs[3].exp_wr_pc = 5;
        vecs[3].exp_wr = 0; vecs[3].exp_pc = 11'd11;

        for (int v = 0; v < 4; v++) begin
            reset = 1'b0;
            clear_pmem();
            for (int i = 0; i < 16; i++) pmem[i] = vecs[v].prog[i];
            pulse_reset();
            chk("vec_first_fetch_pc", 32'(addr_program), 32'd0);
            run_to_halt(100, cyc, nwp, nw, wa, wv);
            chk("vec_halt_cycle", 32'(cyc), 32'(vecs[v].exp_cycles));
            chk("vec_acc", 32'(acc), 32'(vecs[v].exp_acc));
            chk("vec_pc", 32'(addr_program), 32'(vecs[v].exp_pc));
            chk("vec_wr_pc_count", 32'(nwp), 32'(vecs[v].exp_wr_pc));
            chk("vec_wr_count", 32'(nw), 32'(vecs[v].exp_wr));
            if (vecs[v].exp_wr > 0) begin
                chk("vec_wr_addr", 32'(wa), 32'(vecs[v].exp_wr_addr));
                chk("vec_wr_data", 32'(wv), 32'(vecs[v].exp_wr_val));
            end
            for (int j = 0; j < 3; j++) begin
                @(posedge clk);
                #1;
                chk("halt_stays", 32'(halted), 32'd1);
                chk("halt_no_wr_pc", 32'(wr_pc), 32'd0);
                chk("halt_no_wr", 32'(wr), 32'd0);
                chk("halt_acc_frozen", 32'(acc), 32'(vecs[v].exp_acc));
                chk("halt_pc_frozen", 32'(addr_program), 32'(vecs[v].exp_pc));
            end
            $display("vec %0d: halt_cycle=%0d acc=%h pc=%h wr_pc=%0d wr=%0d",
                     v, cyc, acc, addr_program, nwp, nw);
        end

        // Reset during MEM of ADD: LDI 7; STO 3; ADD 3; HLT
        reset = 1'b0;
        clear_pmem();
        pmem[0] = 16'h1807; pmem[1] = 16'h0803; pmem[2] = 16'h2003; pmem[3] = 16'h0000;
        pulse_reset();
        repeat (9) begin @(posedge clk); #1; end
        chk("mem_cycle_wr_pc", 32'(wr_pc), 32'd1);
        chk("mem_cycle_acc", 32'(acc), 32'h7);
        reset = 1'b0;
        #1;
        chk("rst_in_mem_acc", 32'(acc), 32'd0);
        chk("rst_in_mem_wr", 32'(wr), 32'd0);
        chk("rst_in_mem_pc", 32'(addr_program), 32'd0);
        chk("rst_in_mem_addr_data", 32'(addr_data), 32'd0);
        chk("rst_in_mem_wr_pc", 32'(wr_pc), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        run_to_halt(100, cyc, nwp, nw, wa, wv);
        chk("rerun_a_cycle", 32'(cyc), 32'd13);
        chk("rerun_a_acc", 32'(acc), 32'h000E);
        chk("rerun_a_wr", 32'(nw), 32'd1);
        $display("seq reset-in-mem: halt_cycle=%0d acc=%h", cyc, acc);

        // Reset during EXEC of STO (write strobe active)
        pulse_reset();
        repeat (5) begin @(posedge clk); #1; end
        chk("sto_exec_wr", 32'(wr), 32'd1);
        chk("sto_exec_addr_data", 32'(addr_data), 32'd3);
        chk("sto_exec_out_data", 32'(out_data), 32'h7);
        reset = 1'b0;
        #1;
        chk("rst_in_sto_wr", 32'(wr), 32'd0);
        chk("rst_in_sto_acc", 32'(acc), 32'd0);
        chk("rst_in_sto_pc", 32'(addr_program), 32'd0);
        chk("rst_in_sto_out_data", 32'(out_data), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        run_to_halt(100, cyc, nwp, nw, wa, wv);
        chk("rerun_b_cycle", 32'(cyc), 32'd13);
        chk("rerun_b_acc", 32'(acc), 32'h000E);
        chk("rerun_b_wr_pc", 32'(nwp), 32'd3);
        $display("seq reset-in-sto: halt_cycle=%0d acc=%h", cyc, acc);

        // Random programs against the ISA-level model
        for (int r = 0; r < 30; r++) run_random(r);

        // Small instance: unknown opcodes everywhere, PC wraps 15 -> 0
        for (int i = 0; i < 16; i++) p2_pmem[i] = {8'd31, 4'($urandom_range(0, 15))};
        p2_pmem[5]  = 12'hC83;   // opcode 200
        p2_pmem[11] = 12'h127;   // opcode 18
        p2_reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        p2_reset = 1'b1;
        #1;
        p2_wr_cnt = 0;
        for (int k = 0; k < 18; k++) begin
            chk("p2_fetch_pc", 32'(p2_addr_program), 32'(k % 16));
            for (int j = 0; j < 3; j++) begin
                chk("p2_wr_pc", 32'(p2_wr_pc), (j == 2) ? 32'd1 : 32'd0);
                if (p2_wr === 1'b1) p2_wr_cnt++;
                @(posedge clk);
                #1;
            end
        end
        chk("p2_acc", 32'(p2_acc), 32'd0);
        chk("p2_wr_count", 32'(p2_wr_cnt), 32'd0);
        chk("p2_halted", 32'(p2_halted), 32'd0);
        $display("small core: 18 NOPs, pc=%h acc=%h", p2_addr_program, p2_acc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
